// File: rtl/float_stream_sorter.sv
// Streaming insertion sorter for sign/exponent/mantissa words.
// Loads up to K words, keeps them ordered on arrival, then drains in order.
module float_stream_sorter #(
  parameter int NK = 23,
  parameter int M  = 8,
  parameter int L  = NK + M + 1,
  parameter int K  = 10,
  parameter int CW = $clog2(K + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          descending,
  input  logic [L-1:0]  in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [L-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  localparam logic [CW-1:0] KMAX = CW'(K);

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rd_q, rd_d;
  logic          done_q, done_d;
  logic [L-1:0]  slot_q [K];
  logic [L-1:0]  slot_d [K];
  logic [K-1:0]  ahead;
  logic [L-1:0]  key_in;
  logic          accept;

  // Monotonic unsigned key: flip sign for positives, flip all for negatives.
  function automatic logic [L-1:0] key_f(input logic [L-1:0] w);
    return w[L-1] ? ~w : {1'b1, w[L-2:0]};
  endfunction

  assign key_in = key_f(in_data);

  // ahead[i]: held slot i stays in front of the new word (ties stay ahead).
  always_comb begin
    for (int i = 0; i < K; i++) begin
      if (mode_q) ahead[i] = key_f(slot_q[i]) >= key_in;
      else        ahead[i] = key_f(slot_q[i]) <= key_in;
      ahead[i] = ahead[i] && (CW'(i) < cnt_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    slot_d    = slot_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = descending;
          cnt_d   = '0;
          rd_d    = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        in_ready = cnt_q < KMAX;
        accept   = in_valid && in_ready;
        if (accept) begin
          slot_d[0] = ahead[0] ? slot_q[0] : in_data;
          for (int i = 1; i < K; i++) begin
            if (!ahead[i])
              slot_d[i] = ahead[i-1] ? in_data : slot_q[i-1];
          end
          cnt_d = cnt_q + 1'b1;
          if (in_last || cnt_d == KMAX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = slot_q[rd_q];
        out_last  = rd_q == cnt_q - 1'b1;
        if (out_ready) begin
          rd_d = rd_q + 1'b1;
          if (out_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < K; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      slot_q  <= slot_d;
    end
  end

  assign count = cnt_q;
  assign busy  = state_q != IDLE;
  assign done  = done_q;

endmodule
